// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
// The state enum is common to the top and to anything that observes its FSM.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 while not cleared and pulses bit_done
// on the last count, wrapping to 0 so the next bit state starts from zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        bit_done = ~clear && (cnt_q == CNT_LAST);
        if (clear || bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an upstream synchronous FIFO: pops a word in IDLE,
// captures it from the registered read port in LOAD, then shifts out the frame LSB-first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tx_enable,
    input  logic                 fifo_empty,
    output logic                 pop,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 tx,
    output logic                 busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   baud_clear;
    logic                   bit_done;

    // The baud timer only runs in the serial bit states; it wraps on its own at each bit end.
    assign baud_clear = (state_q == IDLE) || (state_q == LOAD);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by reset so a held reset never drains the FIFO.
                pop  = reset_n & tx_enable & ~fifo_empty;
                tx_d = UART_IDLE_LEVEL;
                if (pop) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                shift_d   = rd_data;
                parity_d  = (PARITY_ODD != 0) ? ~(^rd_data) : (^rd_data);
                bit_idx_d = '0;
                state_d   = START;
                tx_d      = UART_START_LEVEL;
            end

            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end

            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = UART_IDLE_LEVEL;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_d[0];
                    end
                end
            end

            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = UART_IDLE_LEVEL;
                end
            end

            STOP: begin
                tx_d = UART_IDLE_LEVEL;
                if (bit_done) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d    = IDLE;
                        stop_cnt_d = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

UART transmitter that drains a synchronous FIFO placed directly upstream. It pops one word whenever the FIFO is non-empty and transmission is enabled. The word is captured from the FIFO's registered read port and shifted out LSB-first as a standard asynchronous serial frame: start bit, data, optional parity, stop bits. It is the TX back end of the FIFO/UART path.

## Interface
- `DATA_BITS`, 8: data bits per frame; must equal the upstream FIFO `DATA_WIDTH`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity; 0 selects even. Ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `tx_enable`, in, 1: permits starting new frames.
- `fifo_empty`, in, 1: upstream FIFO empty flag.
- `pop`, out, 1: read request to the upstream FIFO.
- `rd_data`, in, `DATA_BITS`: upstream FIFO read data, valid the cycle after `pop`.
- `tx`, out, 1: serial line; idles high.
- `busy`, out, 1: high while a word is being loaded or a frame is in progress.

## Operation
- FSM states: `IDLE`, `LOAD`, `START`, `DATA`, `PARITY`, `STOP`.
- `IDLE`
  - `pop` = `tx_enable & ~fifo_empty` (combinational, asserted only in `IDLE`).
  - If `pop` is high, next state is `LOAD`; otherwise stay in `IDLE`.
- `LOAD`
  - Capture `rd_data` into the shift register.
  - Compute the parity bit: even = XOR of the data bits; odd = inverted XOR.
  - Go to `START`.
- Bit states:
  - `START`: `tx` = 0.
  - `DATA`: `tx` = shift register bit 0; shift right at the end of each bit. Leave after `DATA_BITS` bits.
  - `PARITY`: entered only if `PARITY_EN`.
  - `STOP`: `tx` = 1 for `STOP_BITS` bits, then return to `IDLE`.
  - Every bit state lasts exactly `CLKS_PER_BIT` cycles, timed by a baud counter counting 0..`CLKS_PER_BIT`-1.
- `tx` is a register, loaded on the same edge as the state transition it belongs to.
- `busy` = (state != `IDLE`).
- Counter widths:
  - Baud counter: `$clog2(CLKS_PER_BIT)`.
  - Bit index: `$clog2(DATA_BITS)`. Stop-bit count uses its own 1-bit counter.
  - Counters reset to 0 on every state entry. No wrap beyond their terminal values.
- Boundary conditions:
  - `tx_enable` deasserted mid-frame: the current frame completes normally; no further `pop`.
  - `fifo_empty` is sampled only in `IDLE`; changes during a frame are ignored.
  - Reset asserted mid-frame: the frame is aborted and the popped word is lost. `tx` goes to 1 asynchronously.

## Timing
- Reset values: `tx` = 1, `pop` = 0, `busy` = 0, state `IDLE`, all counters 0, shift register 0.
- `pop` asserted in cycle N:
  - The FIFO updates `rd_data` at the end of cycle N.
  - `LOAD` occupies cycle N+1.
  - `tx` falls at the start of cycle N+2.
- Frame length F = (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, covering cycles N+2 .. N+1+F.
- `IDLE` is re-entered at cycle N+2+F; a back-to-back `pop` can occur in that same cycle.
- Minimum gap between frames: 2 extra high cycles (the `IDLE` and `LOAD` cycles).
- `pop` is never high for more than one consecutive cycle.

## Structure
- Package `uart_pkg` holds:
  - typedef `tx_state_t` (enum of the six states);
  - localparams `UART_IDLE_LEVEL` = 1'b1 and `UART_START_LEVEL` = 1'b0.
- One sub-module: `uart_baud_cnt`, parameterised by `CLKS_PER_BIT`. Inputs: `clk`, `reset_n`, `clear`. Output: `bit_done`, a one-cycle pulse when the count reaches `CLKS_PER_BIT`-1.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `DATA_BITS` = 8.
1. Hold `reset_n` = 0 with a non-empty FIFO -> `tx` = 1, `pop` = 0, `busy` = 0 throughout.
2. Single word 0xA5, `fifo_empty` falls at cycle 10, `PARITY_EN` = 0:
   - `pop` high in cycle 10 only; `busy` high cycles 11–51.
   - `tx` = 0 in cycles 12–15, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high in cycles 48–51.
   - Back in `IDLE` at cycle 52.
3. FIFO preloaded with 0x00, 0xFF -> second `pop` in cycle 52, second start bit in cycles 54–57, data all 1s.
4. `PARITY_EN` = 1, word 0x07 -> parity bit = 1 with `PARITY_ODD` = 0, and 0 with `PARITY_ODD` = 1. Frame is 44 cycles; `STOP_BITS` = 2 extends it to 48.
5. `tx_enable` dropped during the `DATA` state with 3 words queued -> the current frame completes; no `pop` until `tx_enable` returns high, then the next `pop` comes in the following `IDLE` cycle.
6. `reset_n` pulsed low during the 3rd data bit -> `tx` = 1 and `busy` = 0 immediately. After release, the next `pop` occurs from `IDLE` with the FIFO still non-empty.
